// File: rtl/power_of_2k_pipe_if.sv
// Stream bundle for the power-of-2^k pipe: operand/select in, result/overflow out.
// Latency: none, wires only.
// Backpressure: carries s_ready/m_ready; the pipe drives s_ready from m_ready.
interface power_of_2k_pipe_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 64,
  parameter int SEL_W  = 2
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [SEL_W-1:0]  s_sel;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              m_ovf;
  logic              busy;

  // The pipe's own view: consumes the s_* side, produces the m_* side.
  modport slave (
    input  s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data, m_ovf, busy
  );

  // The surrounding datapath's view: producer and consumer together.
  modport master (
    output s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data, m_ovf, busy
  );
endinterface

// File: rtl/power_of_2k_pipe.sv
// Computes x^(2^k) mod 2^OUT_W by k squarings, k chosen per transaction (clamped to LOG2_EXP).
// Latency: LOG2_EXP cycles, one registered stage per squaring; k=0 passes through all stages.
// Backpressure: per-stage ready chain, s_ready combinational from m_ready; full rate with no bubbles.
module power_of_2k_pipe #(
  parameter int DATA_W   = 32,
  parameter int OUT_W    = 64,
  parameter int LOG2_EXP = 3,
  parameter int SEL_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  power_of_2k_pipe_if.slave  io
);
  localparam int L = LOG2_EXP;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(LOG2_EXP);

  // Stage registers, stage L feeds the output port.
  logic [L:1]       v_q;
  logic [L:1]       ovf_q;
  logic [OUT_W-1:0] data_q [1:L];
  logic [SEL_W-1:0] sel_q  [1:L];

  // Next-state and load enables.
  logic [L:1]       v_d;
  logic [L:1]       ovf_d;
  logic [L:1]       ld;
  logic [OUT_W-1:0] data_d [1:L];
  logic [SEL_W-1:0] sel_d  [1:L];

  // What each stage sees at its input (stage 1 sees the s_* port).
  logic [L:1]       in_v;
  logic [L:1]       in_ovf;
  logic [OUT_W-1:0] in_data [1:L];
  logic [SEL_W-1:0] in_sel  [1:L];

  logic [L+1:1]       rdy;
  logic [2*OUT_W-1:0] prod;

  // Ready ripples back from the consumer: a stage can load if empty or if its successor can.
  always_comb begin
    rdy        = '0;
    rdy[L+1]   = io.m_ready;
    for (int i = L; i >= 1; i--) begin
      rdy[i] = ~v_q[i] | rdy[i+1];
    end
  end

  // Stage inputs: stage 1 takes the zero-extended operand and clamped select, others the previous stage.
  always_comb begin
    in_v       = '0;
    in_ovf     = '0;
    for (int i = 1; i <= L; i++) begin
      in_data[i] = '0;
      in_sel[i]  = '0;
    end
    in_v[1]    = io.s_valid;
    in_ovf[1]  = 1'b0;
    in_data[1] = OUT_W'(io.s_data);
    in_sel[1]  = (io.s_sel > SEL_MAX) ? SEL_MAX : io.s_sel;
    for (int i = 2; i <= L; i++) begin
      in_v[i]    = v_q[i-1];
      in_ovf[i]  = ovf_q[i-1];
      in_data[i] = data_q[i-1];
      in_sel[i]  = sel_q[i-1];
    end
  end

  // Stage i squares when the select asks for at least i squarings, otherwise passes through.
  always_comb begin
    prod  = '0;
    v_d   = v_q;
    ovf_d = '0;
    ld    = '0;
    for (int i = 1; i <= L; i++) begin
      data_d[i] = in_data[i];
      sel_d[i]  = in_sel[i];
      v_d[i]    = rdy[i] ? in_v[i] : v_q[i];
      // Payload only moves with a valid item so bubbles never disturb a held m_data.
      ld[i]     = rdy[i] & in_v[i];
      prod      = {{OUT_W{1'b0}}, in_data[i]} * {{OUT_W{1'b0}}, in_data[i]};
      if (in_sel[i] >= SEL_W'(i)) begin
        data_d[i] = prod[OUT_W-1:0];
        ovf_d[i]  = in_ovf[i] | (|prod[2*OUT_W-1:OUT_W]);
      end else begin
        ovf_d[i]  = in_ovf[i];
      end
    end
  end

  // Pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      ovf_q <= '0;
      for (int i = 1; i <= L; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 1; i <= L; i++) begin
        if (ld[i]) begin
          data_q[i] <= data_d[i];
          sel_q[i]  <= sel_d[i];
          ovf_q[i]  <= ovf_d[i];
        end
      end
    end
  end

  assign io.s_ready = rdy[1];
  assign io.m_valid = v_q[L];
  assign io.m_data  = data_q[L];
  assign io.m_ovf   = ovf_q[L];
  assign io.busy    = |v_q;
endmodule

// File: tb/tb_power_of_2k_pipe.sv
// Scoreboard bench for power_of_2k_pipe: directed vectors, backpressure, reset flush, random traffic.
// Latency: checks 3-cycle handshake-to-valid on the unblocked directed vectors.
// Backpressure: m_ready driven low/random; held outputs checked for stability every cycle.
module tb_power_of_2k_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  power_of_2k_pipe_if u_if ();
  power_of_2k_pipe_if u_if2 ();

  power_of_2k_pipe u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (u_if.slave)
  );

  power_of_2k_pipe #(.LOG2_EXP(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .io    (u_if2.slave)
  );

  typedef struct {
    logic [63:0] data;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: k squarings (k clamped to l) at 128-bit precision.
  function automatic exp_t ref_pow(input logic [31:0] x, input int k, input int l);
    exp_t        r;
    logic [127:0] p;
    logic [63:0]  d;
    logic         o;
    int           n;
    d = {32'b0, x};
    o = 1'b0;
    n = (k > l) ? l : k;
    for (int i = 0; i < n; i++) begin
      p = {64'b0, d} * {64'b0, d};
      d = p[63:0];
      o = o | (|p[127:64]);
    end
    r.data = d;
    r.ovf  = o;
    r.acc  = 0;
    r.lat  = 1'b0;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [31:0] x, input logic [1:0] k,
                      input logic [63:0] ed, input logic eo, input bit lat);
    exp_t e;
    int   n;
    bit   ok;
    u_if.s_valid = 1'b1;
    u_if.s_data  = x;
    u_if.s_sel   = k;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (u_if.s_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      e.data = ed;
      e.ovf  = eo;
      e.acc  = cyc;
      e.lat  = lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    u_if.s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on each output handshake, checks stall stability.
  logic [63:0] hold_d;
  logic        hold_o;
  bit          hold = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {63'b0, u_if.m_valid}, 64'd1);
        chk("hold_data", u_if.m_data, hold_d);
        chk("hold_ovf", {63'b0, u_if.m_ovf}, {63'b0, hold_o});
      end
      if (u_if.m_valid && u_if.m_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_output", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("m_data", u_if.m_data, e.data);
          chk("m_ovf", {63'b0, u_if.m_ovf}, {63'b0, e.ovf});
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
        end
      end
      hold   = u_if.m_valid && !u_if.m_ready;
      hold_d = u_if.m_data;
      hold_o = u_if.m_ovf;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   done;
    int   n;
    u_if.s_valid  = 1'b0;
    u_if.s_data   = '0;
    u_if.s_sel    = '0;
    u_if.m_ready  = 1'b1;
    u_if2.s_valid = 1'b0;
    u_if2.s_data  = '0;
    u_if2.s_sel   = '0;
    u_if2.m_ready = 1'b1;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", {63'b0, u_if.m_valid}, 64'd0);
    chk("rst_busy", {63'b0, u_if.busy}, 64'd0);
    chk("rst_m_data", u_if.m_data, 64'd0);
    chk("rst_m_ovf", {63'b0, u_if.m_ovf}, 64'd0);
    chk("rst_s_ready", {63'b0, u_if.s_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back k=3, unblocked, latency checked.
    send(32'd2, 2'd3, 64'd256, 1'b0, 1'b1);
    send(32'd3, 2'd3, 64'd6561, 1'b0, 1'b1);
    send(32'd10, 2'd3, 64'd100000000, 1'b0, 1'b1);
    @(negedge clk);
    chk("busy_inflight", {63'b0, u_if.busy}, 64'd1);
    drain();

    // Overflow and select boundaries.
    send(32'd256, 2'd3, 64'd0, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 2'd3, 64'hFFFF_FFF8_0000_0001, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 2'd1, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
    send(32'd5, 2'd0, 64'd5, 1'b0, 1'b1);
    send(32'd3, 2'd2, 64'd81, 1'b0, 1'b1);
    drain();

    // Select clamp on a two-stage build.
    u_if2.s_valid = 1'b1;
    u_if2.s_data  = 32'd3;
    u_if2.s_sel   = 2'd3;
    n = 0;
    while (!u_if2.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 u_if2.s_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!u_if2.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("clamp_valid", {63'b0, u_if2.m_valid}, 64'd1);
    chk("clamp_data", u_if2.m_data, 64'd81);
    chk("clamp_ovf", {63'b0, u_if2.m_ovf}, 64'd0);
    @(posedge clk);
    #1;

    // Backpressure: fill with m_ready low, confirm stall, then release.
    u_if.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = ref_pow(32'(i), 2, 3);
      send(32'(i), 2'd2, e.data, e.ovf, 1'b0);
    end
    u_if.s_valid = 1'b1;
    u_if.s_data  = 32'd3;
    u_if.s_sel   = 2'd2;
    @(negedge clk);
    chk("bp_s_ready", {63'b0, u_if.s_ready}, 64'd0);
    chk("bp_m_valid", {63'b0, u_if.m_valid}, 64'd1);
    chk("bp_busy", {63'b0, u_if.busy}, 64'd1);
    fork
      begin
        repeat (6) @(posedge clk);
        #1 u_if.m_ready = 1'b1;
      end
      begin
        for (int i = 3; i < 10; i++) begin
          exp_t eb;
          eb = ref_pow(32'(i), 2, 3);
          send(32'(i), 2'd2, eb.data, eb.ovf, 1'b0);
        end
      end
    join
    drain();

    // Reset with three items in flight.
    u_if.m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      e = ref_pow(32'(i), 3, 3);
      send(32'(i), 2'd3, e.data, e.ovf, 1'b0);
    end
    @(negedge clk);
    chk("pre_rst_busy", {63'b0, u_if.busy}, 64'd1);
    chk("pre_rst_s_ready", {63'b0, u_if.s_ready}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("flush_m_valid", {63'b0, u_if.m_valid}, 64'd0);
    chk("flush_busy", {63'b0, u_if.busy}, 64'd0);
    sb_q.delete();
    u_if.m_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'd2, 2'd3, 64'd256, 1'b0, 1'b1);
    drain();

    // Random traffic: random gaps, random m_ready, random k.
    done = 1'b0;
    fork
      begin
        for (int t = 0; t < 100; t++) begin
          logic [31:0] x;
          logic [1:0]  k;
          exp_t        er;
          x  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 300));
          k  = 2'($urandom_range(0, 3));
          er = ref_pow(x, int'(k), 3);
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          send(x, k, er.data, er.ovf, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 u_if.m_ready = 1'($urandom_range(0, 1));
        end
        u_if.m_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
